// File: rtl/xentry_types.sv
`default_nettype none
// ============================================================================
// Package     : xentry_types
// Description : Shared types for the fetch pipe and L2 handshakes, the
//               instruction-cache state encoding, and helpers that derive
//               the cache address-split widths from its parameters.
// Revision    : 1.0 - initial associative icache types
// ============================================================================
package xentry_types;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } icache_state_e;

    // Storage width for a field that can hold n distinct values; never 0,
    // so degenerate cases (WAYS=1, SETS=1, WORDS=1) still get a legal vector.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int offset_bits(input int line_size);
        return $clog2(line_size);
    endfunction

    function automatic int index_bits(input int cache_size, input int line_size,
                                      input int ways);
        return $clog2(cache_size / (line_size * ways));
    endfunction

    function automatic int tag_bits(input int xlen, input int cache_size,
                                    input int line_size, input int ways);
        return xlen - offset_bits(line_size) - index_bits(cache_size, line_size, ways);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// ============================================================================
// Module      : icache_way
// Description : One way of the instruction cache: per-set valid bit and tag,
//               line data, hit compare on the read port and word/tag write
//               on the write port.
// Ports       : clk, reset (async, active-low)
//               rd_idx_i/rd_tag_i/rd_word_i -> valid_o, hit_o, data_o
//               wr_idx_i, wr_word_i, wr_data_i, wr_data_en_i : fill word write
//               wr_tag_i, wr_tag_en_i : tag write, sets valid
//               inv_en_i : clear valid of wr_idx_i; flush_i : clear all valid
// Revision    : 1.0 - initial
// ============================================================================
module icache_way #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int WORD_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic [WORD_W-1:0] rd_word_i,
    output logic              valid_o,
    output logic              hit_o,
    output logic [XLEN-1:0]   data_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_word_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic              wr_data_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_tag_en_i,
    input  logic              inv_en_i,
    input  logic              flush_i
);

    localparam int NSETS = 2 ** IDX_W;
    localparam int DEPTH = 2 ** (IDX_W + WORD_W);

    logic [NSETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [NSETS];
    logic [XLEN-1:0]  data_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            if (inv_en_i)    valid_q[wr_idx_i] <= 1'b0;
            if (wr_tag_en_i) valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_tag_en_i)  tag_q[wr_idx_i]               <= wr_tag_i;
        if (wr_data_en_i) data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
    end

    assign valid_o = valid_q[rd_idx_i];
    assign hit_o   = valid_o && (tag_q[rd_idx_i] == rd_tag_i);
    assign data_o  = data_q[{rd_idx_i, rd_word_i}];

endmodule
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : icache_assoc
// Description : N-way set-associative instruction cache between the fetch
//               pipe and L2. Zero-latency hits, line fill from L2 one word
//               per handshake, invalid-way-first then per-set round-robin
//               replacement, whole-cache flush.
// Ports       : clk, reset (async, active-low)
//               pipe_req_* / pipe_fetched_word / pipe_req_fulfilled : fetch
//               l2_req_* / l2_fetched_word / l2_req_fulfilled      : fill
//               flush_req (level) / flush_done (pulse)
// Revision    : 1.0 - initial
// ============================================================================
module icache_assoc
    import xentry_types::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int XLEN       = 32,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pipe_req_address,
    input  memory_operation_e pipe_req_type,
    input  logic              pipe_req_valid,
    output logic [XLEN-1:0]   pipe_fetched_word,
    output logic              pipe_req_fulfilled,
    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled,
    input  logic              flush_req,
    output logic              flush_done
);

    localparam int WORDS   = LINE_SIZE * 8 / XLEN;
    localparam int SETS    = CACHE_SIZE / (LINE_SIZE * WAYS);
    localparam int OFF_W   = offset_bits(LINE_SIZE);
    localparam int IDX_W   = index_bits(CACHE_SIZE, LINE_SIZE, WAYS);
    localparam int TAG_W   = tag_bits(XLEN, CACHE_SIZE, LINE_SIZE, WAYS);
    localparam int BYTE_W  = $clog2(XLEN / 8);
    localparam int IDX_SW  = width_of(SETS);
    localparam int WORD_SW = width_of(WORDS);
    localparam int WAY_SW  = width_of(WAYS);

    // Field extraction by shift-and-mask so zero-width fields need no slicing.
    function automatic logic [IDX_SW-1:0] idx_of(input logic [XLEN-1:0] a);
        return IDX_SW'((a >> OFF_W) & XLEN'(SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] a);
        return TAG_W'(a >> (OFF_W + IDX_W));
    endfunction

    function automatic logic [WORD_SW-1:0] word_of(input logic [XLEN-1:0] a);
        return WORD_SW'((a >> BYTE_W) & XLEN'(WORDS - 1));
    endfunction

    icache_state_e      state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [WORD_SW-1:0] cnt_q, cnt_d;
    logic [WAY_SW-1:0]  victim_q, victim_d;
    logic [WAY_SW-1:0]  rr_q [2 ** IDX_SW];

    logic               miss, fill_we, fill_last, flush_all, rr_adv;
    logic [IDX_SW-1:0]  pipe_idx, fill_idx, wr_idx;
    logic [WAY_SW-1:0]  victim_sel;
    logic               any_hit;
    logic [XLEN-1:0]    hit_data;
    logic               pipe_read;

    logic [WAYS-1:0]    way_valid, way_hit;
    logic [XLEN-1:0]    way_data [WAYS];

    assign pipe_idx  = idx_of(pipe_req_address);
    assign fill_idx  = idx_of(addr_q);
    // Invalidation happens in IDLE against the incoming address; fill writes
    // target the latched address.
    assign wr_idx    = (state_q == IDLE) ? pipe_idx : fill_idx;
    assign pipe_read = pipe_req_valid && (pipe_req_type == READ);

    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            icache_way #(
                .XLEN   (XLEN),
                .TAG_W  (TAG_W),
                .IDX_W  (IDX_SW),
                .WORD_W (WORD_SW)
            ) u_way (
                .clk          (clk),
                .reset        (reset),
                .rd_idx_i     (pipe_idx),
                .rd_tag_i     (tag_of(pipe_req_address)),
                .rd_word_i    (word_of(pipe_req_address)),
                .valid_o      (way_valid[w]),
                .hit_o        (way_hit[w]),
                .data_o       (way_data[w]),
                .wr_idx_i     (wr_idx),
                .wr_word_i    (cnt_q),
                .wr_data_i    (l2_fetched_word),
                .wr_data_en_i (fill_we && (victim_q == WAY_SW'(w))),
                .wr_tag_i     (tag_of(addr_q)),
                .wr_tag_en_i  (fill_last && (victim_q == WAY_SW'(w))),
                .inv_en_i     (miss && (victim_d == WAY_SW'(w))),
                .flush_i      (flush_all)
            );
        end
    endgenerate

    // A line is only ever installed after a miss in every way of its set, so
    // at most one way can match and an OR-merge of the data is exact.
    always_comb begin
        any_hit  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_data = hit_data | way_data[w];
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        victim_sel = rr_q[pipe_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim_sel = WAY_SW'(w);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        victim_d  = victim_q;
        miss      = 1'b0;
        fill_we   = 1'b0;
        fill_last = 1'b0;
        flush_all = 1'b0;
        rr_adv    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (pipe_read && !any_hit) begin
                    miss     = 1'b1;
                    addr_d   = pipe_req_address;
                    cnt_d    = '0;
                    victim_d = victim_sel;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (l2_req_fulfilled) begin
                    fill_we = 1'b1;
                    if (cnt_q == WORD_SW'(WORDS - 1)) begin
                        fill_last = 1'b1;
                        rr_adv    = (victim_q == rr_q[fill_idx]);
                        // A flush that arrived mid-fill is taken right away.
                        state_d   = flush_req ? FLUSH : IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_all = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            victim_q <= '0;
            for (int s = 0; s < 2 ** IDX_SW; s++) rr_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (flush_all) begin
                for (int s = 0; s < 2 ** IDX_SW; s++) rr_q[s] <= '0;
            end else if (rr_adv) begin
                rr_q[fill_idx] <= (WAYS == 1) ? '0 : WAY_SW'(rr_q[fill_idx] + 1'b1);
            end
        end
    end

    assign pipe_req_fulfilled = (state_q == IDLE) && !flush_req && pipe_read && any_hit;
    assign pipe_fetched_word  = pipe_req_fulfilled ? hit_data : '0;
    assign l2_req_valid       = (state_q == FILL);
    assign l2_req_address     = (state_q == FILL)
                              ? ((addr_q & ~XLEN'(LINE_SIZE - 1)) | (XLEN'(cnt_q) << BYTE_W))
                              : '0;
    assign l2_req_type        = READ;
    assign flush_done         = (state_q == FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_assoc
// Description : Self-checking bench for icache_assoc with default parameters
//               (2 ways, 16 sets, 8-word lines). L2 is modelled by a data
//               function of the address; expected L2 addresses and pipe words
//               are queued when a read is issued and popped as they appear.
// Revision    : 1.0 - initial
// ============================================================================
module tb_icache_assoc;
    import xentry_types::*;

    localparam int WORDS = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       pipe_req_address = '0;
    memory_operation_e pipe_req_type = READ;
    logic              pipe_req_valid = 1'b0;
    logic [31:0]       pipe_fetched_word;
    logic              pipe_req_fulfilled;
    logic [31:0]       l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [31:0]       l2_fetched_word = '0;
    logic              l2_req_fulfilled = 1'b0;
    logic              flush_req = 1'b0;
    logic              flush_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] l2_q[$];
    logic [31:0] pipe_q[$];

    always #5 clk = ~clk;

    icache_assoc dut (
        .clk                (clk),
        .reset              (reset),
        .pipe_req_address   (pipe_req_address),
        .pipe_req_type      (pipe_req_type),
        .pipe_req_valid     (pipe_req_valid),
        .pipe_fetched_word  (pipe_fetched_word),
        .pipe_req_fulfilled (pipe_req_fulfilled),
        .l2_req_address     (l2_req_address),
        .l2_req_type        (l2_req_type),
        .l2_req_valid       (l2_req_valid),
        .l2_fetched_word    (l2_fetched_word),
        .l2_req_fulfilled   (l2_req_fulfilled),
        .flush_req          (flush_req),
        .flush_done         (flush_done)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] + 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_fulfilled"}, 32'(pipe_req_fulfilled), 32'd0);
        chk({name, "_word"},      pipe_fetched_word,       32'd0);
        chk({name, "_l2_valid"},  32'(l2_req_valid),       32'd0);
        chk({name, "_l2_addr"},   l2_req_address,          32'd0);
        chk({name, "_l2_type"},   32'(l2_req_type),        32'd0);
        chk({name, "_flush"},     32'(flush_done),         32'd0);
    endtask

    // Issue one pipe read and service it. Negative stall/flush/reset word
    // numbers disable that corner case. The L2 model answers in the same
    // cycle it sees a request unless that word is being stalled.
    task automatic run_read(input logic [31:0] addr, input bit exp_miss,
                            input int stall_word, input int stall_len,
                            input int flush_word, input int reset_word);
        int cyc;
        int fills;
        int stall_left;
        bit fin_fill;
        bit done;
        @(negedge clk);
        pipe_req_address = addr;
        pipe_req_type    = READ;
        pipe_req_valid   = 1'b1;
        if (exp_miss)
            for (int i = 0; i < WORDS; i++) l2_q.push_back((addr & ~32'h1F) + 32'(4 * i));
        if (flush_word < 0 && reset_word < 0) pipe_q.push_back(mem_word(addr & ~32'h3));
        cyc = 0; fills = 0; stall_left = stall_len; fin_fill = 1'b0; done = 1'b0;
        while (!done) begin
            #1;
            if (cyc > 200) begin
                chk("timeout", 32'(cyc), 32'd200);
                l2_q.delete(); pipe_q.delete();
                pipe_req_valid = 1'b0; flush_req = 1'b0; l2_req_fulfilled = 1'b0;
                done = 1'b1;
            end else if (fin_fill) begin
                chk("flush_done_pulse", 32'(flush_done), 32'd1);
                chk("flush_no_fulfil", 32'(pipe_req_fulfilled), 32'd0);
                flush_req = 1'b0;
                @(negedge clk); #1;
                chk("flush_done_single", 32'(flush_done), 32'd0);
                chk("flush_then_idle", 32'(l2_req_valid), 32'd0);
                done = 1'b1;
            end else if (pipe_req_fulfilled) begin
                chk("fills_outstanding", 32'(l2_q.size()), 32'd0);
                if (pipe_q.size() == 0) chk("pipe_unexpected", 32'd1, 32'd0);
                else chk("pipe_word", pipe_fetched_word, pipe_q.pop_front());
                // Request cycle is cyc 0; the miss cycle, WORDS fill cycles,
                // then the hit: WORDS + 2 cycles inclusive.
                if (exp_miss && stall_word < 0) chk("miss_latency", 32'(cyc), 32'(WORDS + 1));
                if (!exp_miss) chk("hit_latency", 32'(cyc), 32'd0);
                pipe_req_valid = 1'b0;
                done = 1'b1;
            end else if (l2_req_valid) begin
                chk("l2_type", 32'(l2_req_type), 32'(READ));
                if (flush_word >= 0) chk("flush_done_early", 32'(flush_done), 32'd0);
                if (l2_q.size() == 0) begin
                    chk("l2_unexpected", l2_req_address, 32'd0);
                    done = 1'b1;
                    pipe_req_valid = 1'b0;
                end else if (fills == reset_word) begin
                    chk("reset_word_addr", l2_req_address, l2_q[0]);
                    reset = 1'b0;
                    #1;
                    chk_all_zero("reset_mid_fill");
                    l2_q.delete();
                    pipe_req_valid = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    done = 1'b1;
                end else if (fills == stall_word && stall_left > 0) begin
                    chk("stall_addr", l2_req_address, l2_q[0]);
                    chk("stall_no_fulfil", 32'(pipe_req_fulfilled), 32'd0);
                    stall_left--;
                end else begin
                    chk("l2_addr", l2_req_address, l2_q.pop_front());
                    l2_fetched_word  = mem_word(l2_req_address);
                    l2_req_fulfilled = 1'b1;
                    fills++;
                    if (fills == flush_word) begin
                        flush_req      = 1'b1;
                        pipe_req_valid = 1'b0;
                    end
                    if (flush_word >= 0 && fills == WORDS) fin_fill = 1'b1;
                end
            end
            if (!done) begin
                @(negedge clk);
                l2_req_fulfilled = 1'b0;
                cyc++;
            end
        end
    endtask

    // Single-cycle combinational probe; request withdrawn before the edge.
    task automatic probe(input string name, input logic [31:0] addr,
                         input logic exp_ful, input logic [31:0] exp_word);
        @(negedge clk);
        pipe_req_address = addr;
        pipe_req_type    = READ;
        pipe_req_valid   = 1'b1;
        #1;
        chk({name, "_fulfilled"}, 32'(pipe_req_fulfilled), 32'(exp_ful));
        chk({name, "_word"},      pipe_fetched_word,       exp_word);
        pipe_req_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0]       addr;
        memory_operation_e typ;
        logic              flush;
        logic              exp_ful;
        logic [31:0]       exp_word;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_101C, READ,  1'b0, 1'b1, mem_word(32'h0000_101C)};
        vecs[1] = '{32'h0000_1000, READ,  1'b0, 1'b1, mem_word(32'h0000_1000)};
        vecs[2] = '{32'h0000_1010, READ,  1'b0, 1'b1, mem_word(32'h0000_1010)};
        vecs[3] = '{32'h0000_1012, READ,  1'b0, 1'b1, mem_word(32'h0000_1010)};
        vecs[4] = '{32'h0000_1004, WRITE, 1'b0, 1'b0, 32'd0};
        vecs[5] = '{32'h0000_1004, READ,  1'b1, 1'b0, 32'd0};
        vecs[6] = '{32'h0000_2000, READ,  1'b0, 1'b0, 32'd0};
        vecs[7] = '{32'h0000_1020, READ,  1'b0, 1'b0, 32'd0};

        #2 reset = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Cold miss then hit on the requested word.
        run_read(32'h0000_1004, 1'b1, -1, 0, -1, -1);
        // Hit after fill, zero latency.
        run_read(32'h0000_101C, 1'b0, -1, 0, -1, -1);

        // Table of single-cycle probes: hits, ignored low bits, non-READ,
        // flush priority and misses that are withdrawn before the edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pipe_req_address = vecs[i].addr;
            pipe_req_type    = vecs[i].typ;
            flush_req        = vecs[i].flush;
            pipe_req_valid   = 1'b1;
            #1;
            chk($sformatf("vec%0d_fulfilled", i), 32'(pipe_req_fulfilled), 32'(vecs[i].exp_ful));
            chk($sformatf("vec%0d_word", i), pipe_fetched_word, vecs[i].exp_word);
            pipe_req_valid = 1'b0;
            flush_req      = 1'b0;
            pipe_req_type  = READ;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_no_l2", i), 32'(l2_req_valid), 32'd0);
            chk($sformatf("vec%0d_no_flush", i), 32'(flush_done), 32'd0);
        end

        // Conflict in set 0: 0x2000 takes way 1, 0x3000 evicts way 0.
        run_read(32'h0000_2000, 1'b1, -1, 0, -1, -1);
        run_read(32'h0000_3000, 1'b1, -1, 0, -1, -1);
        run_read(32'h0000_2000, 1'b0, -1, 0, -1, -1);
        probe("evicted_1000", 32'h0000_1000, 1'b0, 32'd0);
        probe("kept_3000", 32'h0000_3004, 1'b1, mem_word(32'h0000_3004));
        // Refill 0x1000 with a 5-cycle L2 stall on word 3 (address 0x100C).
        run_read(32'h0000_1008, 1'b1, 3, 5, -1, -1);

        // Flush raised during a fill; 0x1000 must miss afterwards.
        run_read(32'h0000_4000, 1'b1, -1, 0, 2, -1);
        probe("after_flush_1000", 32'h0000_1000, 1'b0, 32'd0);
        run_read(32'h0000_1000, 1'b1, -1, 0, -1, -1);

        // Reset at word 4, then the same line refills from word 0.
        run_read(32'h0000_6000, 1'b1, -1, 0, -1, 4);
        run_read(32'h0000_6000, 1'b1, -1, 0, -1, -1);
        probe("after_reset_1000", 32'h0000_1000, 1'b0, 32'd0);

        chk("pipe_q_drained", 32'(pipe_q.size()), 32'd0);
        chk("l2_q_drained", 32'(l2_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
